// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader state encoding and the default bus widths.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // A LEN byte of zero describes a full 2^ADDR_W-byte image.
  localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in, fetch port, CPU status out, plus FSM state for observation.
// Stream handshake: a byte transfers on a rising CLK edge where in_valid and in_ready are both 1.
// in_ready depends on loader state only, so a source may hold in_valid/in_data until it sees in_ready.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  state_t            dbg_state;

  modport master (
    output start, in_valid, in_data, fetch_addr,
    input  in_ready, fetch_data, cpu_hold, done, err, dbg_state
  );

  modport slave (
    input  start, in_valid, in_data, fetch_addr,
    output in_ready, fetch_data, cpu_hold, done, err, dbg_state
  );
endinterface

// File: rtl/imem_ram.sv
// 2^ADDR_W x DATA_W instruction store: synchronous write, asynchronous read,
// and the whole array cleared asynchronously by CLB.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Framed program loader (LEN, data bytes, CSUM) in front of the instruction store;
// keeps the CPU held until a frame with a matching checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic         CLK,
  input logic         CLB,
  imem_loader_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_sum;
  logic               w_ready;
  logic               w_accept;
  logic               w_we;
  logic [CNT_W-1:0]   w_len_cnt;
  logic [DATA_W-1:0]  w_rdata;

  assign w_accept  = bus.in_valid & w_ready;
  assign w_len_cnt = ((bus.in_data == '0) && LEN_ZERO_MEANS_FULL) ?
                     CNT_W'(2 ** ADDR_W) : CNT_W'(bus.in_data);

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (bus.start) w_next = ST_LEN;
      end
      ST_LEN: begin
        w_ready = 1'b1;
        if (w_accept) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_we = 1'b1;
          if (r_cnt == CNT_W'(1)) w_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        w_ready = 1'b1;
        if (w_accept) w_next = (bus.in_data == r_sum) ? ST_RUN : ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Pointer, remaining count and running checksum for the frame in flight.
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_sum <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (bus.start) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_sum <= '0;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            r_cnt <= w_len_cnt;
            r_sum <= bus.in_data;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
            r_sum <= r_sum + bus.in_data;
          end
        end
        default: ;
      endcase
    end
  end

  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .CLK     (CLK),
    .CLB     (CLB),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (bus.fetch_addr),
    .o_rdata (w_rdata)
  );

  assign bus.fetch_data = w_rdata;
  assign bus.in_ready   = w_ready;
  assign bus.cpu_hold   = (r_state != ST_RUN);
  assign bus.done       = (r_state == ST_RUN);
  assign bus.err        = (r_state == ST_ERR);
  assign bus.dbg_state  = r_state;

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream program loader, sitting directly upstream of the instruction register in the 8-bit accumulator processor. It receives a framed program image over a valid/ready byte interface and writes it into a 256 x 8 store. It serves instruction fetches from the program counter address combinationally. It holds the CPU frozen until a frame with a valid checksum has been loaded.

## Interface
- ADDR_W, 8, fetch and write address width; depth is 2^ADDR_W.
- DATA_W, 8, instruction and stream byte width.

Ports:
- CLK  in  1  processor clock; all state changes on the rising edge.
- CLB  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a load.
- in_valid  in  1  stream byte present.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- fetch_addr  in  ADDR_W  instruction address from the program counter.
- fetch_data  out  DATA_W  instruction at fetch_addr; combinational read.
- cpu_hold  out  1  drives the CPU's reset and freeze; 1 = CPU halted.
- done  out  1  a valid program is loaded; CPU is running.
- err  out  1  the last frame failed its checksum.

## Operation
- Frame layout: LEN byte, then N data bytes, then CSUM byte.
  - N = LEN, except LEN = 0 means N = 256.
  - The required CSUM is (LEN + sum of data bytes) mod 256.
- The loader FSM has six states: IDLE, LEN, DATA, CSUM, RUN, ERR.
- Transitions:
  - IDLE, RUN or ERR with start = 1 -> LEN. The write pointer and running sum are cleared.
  - LEN with a byte accepted -> DATA. The byte is latched as the count, and the sum is set to that byte.
  - DATA with a byte accepted: the byte is written at the pointer, the pointer increments, the sum accumulates, and the count decrements. When the final data byte is accepted -> CSUM.
  - CSUM with a byte accepted: a byte equal to the sum -> RUN; any other byte -> ERR.
- A byte is accepted on a rising edge where in_valid = 1 and in_ready = 1.
- in_ready = 1 only in LEN, DATA and CSUM. It is a pure function of state.
- start is ignored in LEN, DATA and CSUM.
- If start and in_valid are both high in IDLE, RUN or ERR, start wins. No byte is consumed, because in_ready is low in those states.
- Output decode:
  - cpu_hold = 1 in every state except RUN.
  - done = 1 only in RUN.
  - err = 1 only in ERR.
- Memory contents:
  - Reset clears all locations to 0x00.
  - A new load overwrites only locations 0 to N-1; all other locations keep their old values.
  - ERR keeps the partially written data.
- The write pointer is ADDR_W bits and wraps modulo 256. For N = 256, the last byte is written at 0xFF and the pointer returns to 0x00.
- fetch_data always reflects the memory, in every state, including while loading.

## Timing
- Reset values:
  - FSM state: IDLE.
  - in_ready = 0, cpu_hold = 1, done = 0, err = 0.
  - All memory locations = 0x00.
- Read latency is 0: fetch_data follows fetch_addr combinationally.
- A byte written on edge k is visible on fetch_data after edge k.
- CSUM check:
  - The CSUM byte is accepted on edge k.
  - On a match, done = 1 and cpu_hold = 0 starting in the cycle after edge k. The CPU's first fetch is at address 0x00.
  - On a mismatch, err = 1 starting in the cycle after edge k.
- Reset mid-frame: the FSM returns asynchronously to IDLE and the memory is cleared. The partial frame is discarded.
- Stall cycles (in_valid = 0) are allowed anywhere in a frame. The loader has no timeout.

## Structure
- The shared package `imem_loader_pkg` holds:
  - the state enum: IDLE, LEN, DATA, CSUM, RUN, ERR;
  - constant LEN_ZERO_MEANS_FULL = 1;
  - the default widths.
- One sub-module, `imem_ram`:
  - 2^ADDR_W x DATA_W storage;
  - synchronous write (we, waddr, wdata);
  - asynchronous read;
  - asynchronous clear on CLB.
- The FSM, counters and checksum live in `imem_loader`.

## Test plan
- **Reset:** assert CLB; fetch_addr = 0x05 -> cpu_hold = 1, in_ready = 0, done = 0, err = 0, fetch_data = 0x00.
- **Good frame:** start, then stream 03 A1 B2 C3 19 -> done = 1, cpu_hold = 0 in the cycle after CSUM is accepted. Addresses 0, 1, 2, 3 read A1, B2, C3, 00.
- **Bad checksum:** stream 03 A1 B2 C3 18 -> err = 1, cpu_hold = 1, done = 0. Addresses 0 to 2 still read A1, B2, C3.
- **Full frame with wrap:** LEN = 00, data bytes i = 0x00 to 0xFF, CSUM = 80 -> done = 1. Address 0xFF reads FF, address 0x00 reads 00.
- **Stalls and ignored start:**
  - toggle in_valid with gaps and pulse start during DATA -> only handshaked bytes are written, and the frame completes normally;
  - pulse start in RUN -> the FSM re-enters LEN and cpu_hold = 1.
- **Reset mid-frame:** after LEN = 04 and 2 data bytes, pulse CLB -> IDLE, cpu_hold = 1, addresses 0 and 1 read 00. A subsequent good frame loads correctly.
